// File: rtl/reg_bridge.sv
// CPU-to-register bridge: local control/status registers in window 0 and
// NSLV external slave windows with a request/ack handshake and a timeout.
module reg_bridge #(
  parameter int NSLV = 2,
  parameter int NREG = 8,
  parameter int TMO  = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [31:0]          armaddr,
  input  logic [31:0]          armwdata,
  input  logic [3:0]           armwstrb,
  input  logic                 armwr,
  input  logic                 armreq,
  output logic                 armack,
  output logic                 armerr,
  output logic [31:0]          armrdata,
  output logic [NREG*32-1:0]   ctl,
  input  logic [31:0]          sts,
  output logic [NSLV-1:0]      sreq,
  output logic                 swr,
  output logic [19:0]          saddr,
  output logic [31:0]          swdata,
  output logic [3:0]           swstrb,
  input  logic [NSLV-1:0]      sack,
  input  logic [NSLV-1:0]      serr,
  input  logic [NSLV*32-1:0]   srdata
);
  localparam logic [0:0]  S_IDLE = 1'b0;
  localparam logic [0:0]  S_WAIT = 1'b1;
  localparam logic [3:0]  NSLV_W = 4'(NSLV);
  localparam logic [17:0] NREG_X = 18'(NREG);
  localparam logic [15:0] TMO_C  = 16'(TMO);

  typedef struct packed {
    logic        wr;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } sreq_t;

  logic [0:0]            state;
  logic                  armreq0;
  logic [15:0]           cnt;
  logic [3:0]            sel;
  sreq_t                 lat;
  logic [NREG-1:0][31:0] regs;

  logic [3:0]  w;
  logic [17:0] x;
  logic        start, ext, tmo;
  logic        s_ack, s_err;
  logic [31:0] s_rd, reg_rd;
  logic        unused_addr;

  assign w           = armaddr[23:20];
  assign x           = armaddr[19:2];
  assign unused_addr = ^{armaddr[31:24], armaddr[1:0]};
  // The ack cycle blocks a start so an edge landing there is dropped, not queued.
  assign start = (state == S_IDLE) && !armack && armreq && !armreq0;
  assign ext   = (w != 4'd0) && (w <= NSLV_W);
  assign tmo   = (TMO != 0) && (cnt == TMO_C);

  assign ctl    = regs;
  assign swr    = lat.wr;
  assign saddr  = lat.addr;
  assign swdata = lat.wdata;
  assign swstrb = lat.strb;

  always_comb begin
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rd  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel == 4'(i)) begin
        s_ack = sack[i];
        s_err = serr[i];
        s_rd  = srdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    reg_rd = '0;
    for (int k = 0; k < NREG; k++)
      if (x == 18'(k)) reg_rd = regs[k];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      armreq0  <= 1'b0;
      armack   <= 1'b0;
      armerr   <= 1'b0;
      armrdata <= '0;
      regs     <= '0;
      sreq     <= '0;
      lat      <= '0;
      cnt      <= '0;
      sel      <= '0;
    end else begin
      armreq0 <= armreq;
      armack  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (ext) begin
              state <= S_WAIT;
              sel   <= w - 4'd1;
              sreq  <= NSLV'(1) << (w - 4'd1);
              lat   <= '{wr: armwr, addr: armaddr[19:0], wdata: armwdata, strb: armwstrb};
              cnt   <= '0;
            end else begin
              armack <= 1'b1;
              if (w == 4'd0 && x < NREG_X) begin
                armerr <= 1'b0;
                if (armwr) begin
                  for (int k = 0; k < NREG; k++)
                    if (x == 18'(k))
                      for (int b = 0; b < 4; b++)
                        if (armwstrb[b]) regs[k][8*b +: 8] <= armwdata[8*b +: 8];
                end else begin
                  armrdata <= reg_rd;
                end
              end else if (w == 4'd0 && x == NREG_X) begin
                // Status word is read-only; a write is flagged but rdata is kept.
                if (armwr) armerr <= 1'b1;
                else begin
                  armerr   <= 1'b0;
                  armrdata <= sts;
                end
              end else begin
                armerr   <= 1'b1;
                armrdata <= '1;
              end
            end
          end
        end
        S_WAIT: begin
          if (s_ack) begin
            state    <= S_IDLE;
            sreq     <= '0;
            armack   <= 1'b1;
            armerr   <= s_err;
            armrdata <= s_rd;
          end else if (tmo) begin
            state    <= S_IDLE;
            sreq     <= '0;
            armack   <= 1'b1;
            armerr   <= 1'b1;
            armrdata <= '1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_bridge.sv
// Randomized bench for reg_bridge: each access is predicted as a transaction
// (ack cycle, sreq window, result) and checked cycle by cycle.
module tb_reg_bridge;
  localparam int NSLV = 2;
  localparam int NREG = 8;
  localparam int TMO  = 4;

  logic                clk = 1'b0;
  logic                rstn = 1'b1;
  logic [31:0]         armaddr = '0, armwdata = '0, armrdata, sts = '0;
  logic [3:0]          armwstrb = '0, swstrb;
  logic                armwr = 1'b0, armreq = 1'b0, armack, armerr, swr;
  logic [NREG*32-1:0]  ctl;
  logic [NSLV-1:0]     sreq, sack = '0, serr = '0;
  logic [19:0]         saddr;
  logic [31:0]         swdata;
  logic [NSLV*32-1:0]  srdata = '0;

  reg_bridge #(.NSLV(NSLV), .NREG(NREG), .TMO(TMO)) dut (
    .clk(clk), .rstn(rstn), .armaddr(armaddr), .armwdata(armwdata),
    .armwstrb(armwstrb), .armwr(armwr), .armreq(armreq), .armack(armack),
    .armerr(armerr), .armrdata(armrdata), .ctl(ctl), .sts(sts), .sreq(sreq),
    .swr(swr), .saddr(saddr), .swdata(swdata), .swstrb(swstrb), .sack(sack),
    .serr(serr), .srdata(srdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;

  // model state
  logic [31:0]     mctl [NREG];
  logic [31:0]     pend_ctl [NREG];
  bit              pend = 0, hold = 0;
  logic [31:0]     last_rd = '0, e_rd = '0;
  logic            last_err = 1'b0, e_err = 1'b0;
  int              exp_ack = -1, sq_lo = 1, sq_hi = -1;
  logic [NSLV-1:0] sq_val = '0;
  logic [19:0]     e_addr = '0;
  logic [31:0]     e_wd = '0;
  logic [3:0]      e_st = '0;
  logic            e_wr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      last_rd = '0;
      last_err = 1'b0;
      for (int k = 0; k < NREG; k++) mctl[k] = '0;
      chk("rst_armack", 32'(armack), 0);
      chk("rst_armerr", 32'(armerr), 0);
      chk("rst_armrdata", armrdata, 0);
      chk("rst_sreq", 32'(sreq), 0);
      chk("rst_saddr", 32'(saddr), 0);
      chk("rst_swr", 32'(swr), 0);
      chk("rst_swdata", swdata, 0);
      chk("rst_swstrb", 32'(swstrb), 0);
      chk("rst_ctl", 32'(|ctl), 0);
    end else begin
      if (cyc == exp_ack) begin
        if (!hold) last_rd = e_rd;
        last_err = e_err;
        if (pend) mctl = pend_ctl;
      end
      chk("armack", 32'(armack), 32'(cyc == exp_ack));
      chk("armerr", 32'(armerr), 32'(last_err));
      chk("armrdata", armrdata, last_rd);
      if (cyc >= sq_lo && cyc <= sq_hi) begin
        chk("sreq", 32'(sreq), 32'(sq_val));
        chk("saddr", 32'(saddr), 32'(e_addr));
        chk("swr", 32'(swr), 32'(e_wr));
        chk("swdata", swdata, e_wd);
        chk("swstrb", 32'(swstrb), 32'(e_st));
      end else begin
        chk("sreq_idle", 32'(sreq), 0);
      end
      for (int k = 0; k < NREG; k++) chk("ctl", ctl[32*k +: 32], mctl[k]);
    end
  end

  // L: cycle (counted from the first sreq cycle) in which the slave acks.
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                        input bit wr, input int L, input bit re, input logic [31:0] xrd,
                        input bit xerr, input bit from_rst);
    logic [3:0]  w;
    logic [17:0] x;
    int s, n, ack, last, r, wi, xi;
    bit ext;
    w = a[23:20]; x = a[19:2];
    wi = int'(w); xi = int'(x);
    ext = (wi >= 1 && wi <= NSLV);
    armaddr = a; armwdata = wd; armwstrb = st; armwr = wr;
    if (from_rst) rstn = 1'b1; else armreq = 1'b1;
    s = cyc;
    pend = 0; hold = 0;
    r = -1;
    if (ext) begin
      n = (L < TMO + 1) ? L : TMO + 1;
      ack = s + n + 1;
      sq_val = '0; sq_val[wi-1] = 1'b1;
      e_addr = a[19:0]; e_wr = wr; e_wd = wd; e_st = st;
      sq_lo = s + 1; sq_hi = s + n;
      if (L <= TMO + 1) begin e_err = xerr; e_rd = xrd; end
      else begin e_err = 1'b1; e_rd = 32'hFFFFFFFF; end
      if (re) r = $urandom_range(s + 2, ack);
    end else begin
      ack = s + 1;
      if (wi == 0 && xi < NREG) begin
        e_err = 1'b0;
        if (wr) begin
          hold = 1;
          pend_ctl = mctl;
          for (int b = 0; b < 4; b++)
            if (st[b]) pend_ctl[xi][8*b +: 8] = wd[8*b +: 8];
          pend = 1;
        end else e_rd = mctl[xi];
      end else if (wi == 0 && xi == NREG) begin
        if (wr) begin e_err = 1'b1; hold = 1; end
        else begin e_err = 1'b0; e_rd = sts; end
      end else begin
        e_err = 1'b1; e_rd = 32'hFFFFFFFF;
      end
    end
    exp_ack = ack;
    last = ack;
    if (ext && s + L > last) last = s + L;
    while (cyc < last + 1) begin
      @(posedge clk); #1;
      for (int i = 0; i < NSLV; i++) begin
        sack[i] = 1'($urandom);
        serr[i] = 1'($urandom);
        srdata[32*i +: 32] = $urandom;
      end
      if (ext) begin
        sack[wi-1] = (cyc == s + L);
        if (cyc == s + L) begin
          serr[wi-1] = xerr;
          srdata[32*(wi-1) +: 32] = xrd;
        end
      end
      if (re && cyc == s + 1) armreq = 1'b0;
      if (re && cyc == r) armreq = 1'b1;
    end
    armreq = 1'b0;
    sack = '0;
    repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, nerr %0d", nerr);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  w;
    logic [17:0] x;
    logic [7:0]  top;
    logic [1:0]  lo;
    int s;
    for (int k = 0; k < NREG; k++) mctl[k] = '0;
    #2 rstn = 1'b0;
    armreq = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    // armreq already high at release: counts as an edge
    access(32'h00000004, 32'h11223344, 4'b0101, 1, 1, 0, 0, 0, 1);
    chk("req026_ctl1", ctl[63:32], 32'h00220044);
    chk("req026_err", 32'(armerr), 0);

    sts = 32'hCAFEF00D;
    access(32'h00000000 + 4*NREG, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("req027_rd", armrdata, 32'hCAFEF00D);
    access(32'h00000000 + 4*NREG, 32'hDEADBEEF, 4'hF, 1, 1, 0, 0, 0, 0);
    chk("req027_werr", 32'(armerr), 1);
    chk("req027_ctl1", ctl[63:32], 32'h00220044);

    access(32'h00200010, 0, 0, 0, 3, 0, 32'h0BADC0DE, 0, 0);
    chk("req028_rd", armrdata, 32'h0BADC0DE);
    chk("req028_err", 32'(armerr), 0);

    access(32'h00100000, 32'h12345678, 4'hF, 1, TMO + 3, 1, 32'h55555555, 0, 0);
    chk("req029_err", 32'(armerr), 1);
    chk("req029_rd", armrdata, 32'hFFFFFFFF);

    access(32'h00F00000, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("req030_err", 32'(armerr), 1);
    chk("req030_rd", armrdata, 32'hFFFFFFFF);

    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 5))
        0, 1: w = 4'd0;
        2:    w = 4'd1;
        3:    w = 4'd2;
        4:    w = 4'($urandom_range(3, 15));
        default: w = 4'd15;
      endcase
      x = ($urandom_range(0, 3) == 0) ? 18'($urandom) : 18'($urandom_range(0, NREG + 2));
      top = 8'($urandom);
      lo = 2'($urandom);
      sts = $urandom;
      access({top, w, x, lo}, $urandom, 4'($urandom), 1'($urandom),
             $urandom_range(1, TMO + 3), ($urandom_range(0, 2) == 0),
             $urandom, 1'($urandom), 0);
    end

    // reset while waiting on a slave abandons the access
    armaddr = 32'h00200000; armwr = 1'b1; armwdata = 32'hA5A5A5A5; armwstrb = 4'hF;
    armreq = 1'b1;
    s = cyc;
    hold = 0; pend = 0;
    sq_val = 2'b10; e_addr = 20'h0; e_wr = 1'b1; e_wd = 32'hA5A5A5A5; e_st = 4'hF;
    sq_lo = s + 1; sq_hi = s + 1000;
    exp_ack = -1;
    repeat (2) begin @(posedge clk); #1; end
    rstn = 1'b0;
    armreq = 1'b0;
    sq_hi = -1;
    #1 chk("rst_wait_sreq", 32'(sreq), 0);
    repeat (2) begin @(posedge clk); #1; end
    rstn = 1'b1;
    repeat (10) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/reg_bridge.md
REG_BRIDGE -- requirements
Module: reg_bridge

Interface
REQ-001 SHALL have parameter NSLV, default 2: number of external slave windows, legal 1..14.
REQ-002 SHALL have parameter NREG, default 8: number of local 32-bit control registers, legal 1..64.
REQ-003 SHALL have parameter TMO, default 255: external-access timeout in cycles, legal 0..65535; 0 disables the timeout.
REQ-004 Ports, in the form name  direction  width  meaning:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- armaddr  in  32  CPU byte address.
- armwdata  in  32  CPU write data.
- armwstrb  in  4  CPU byte strobes.
- armwr  in  1  1 = write, 0 = read.
- armreq  in  1  request level; its rising edge starts an access.
- armack  out  1  one-cycle completion pulse.
- armerr  out  1  error flag, valid while armack = 1.
- armrdata  out  32  read data, valid while armack = 1.
- ctl  out  NREG*32  local registers; register k occupies bits [32k+31:32k].
- sts  in  32  read-only status word.
- sreq  out  NSLV  per-slave request level.
- swr  out  1  slave write flag.
- saddr  out  20  slave byte address.
- swdata  out  32  slave write data.
- swstrb  out  4  slave byte strobes.
- sack  in  NSLV  per-slave acknowledge.
- serr  in  NSLV  per-slave error, sampled with sack.
- srdata  in  NSLV*32  per-slave read data; slave i occupies bits [32i+31:32i].

Function
REQ-005 SHALL register armreq into armreq0 each cycle; a new access SHALL start only in IDLE when armreq=1 and armreq0=0.
REQ-006 SHALL decode the window as w = armaddr[23:20] and the word index as x = armaddr[19:2]; armaddr[31:24] and armaddr[1:0] SHALL be ignored for decode.
REQ-007 Local window, w=0, for x<NREG: writes SHALL update only the bytes of ctl register x whose armwstrb bit is 1; reads SHALL return register x.
REQ-008 Local window, x=NREG: reads SHALL return sts; writes SHALL change no state and SHALL complete with armerr=1.
REQ-009 Local window, x>NREG, and any window with w>NSLV: SHALL complete with armerr=1, armrdata=32'hFFFFFFFF, and no state change.
REQ-010 Every local and unmapped access SHALL complete with armack=1 exactly one cycle after the start cycle; armerr=0 unless REQ-008 or REQ-009 applies.
REQ-011 External window, 1<=w<=NSLV: the cycle after the start cycle SHALL assert sreq[w-1] and drive saddr=armaddr[19:0], swr, swdata and swstrb from the latched CPU values; these SHALL hold stable until the access completes.
REQ-012 State machine: IDLE -> WAIT on an external start; WAIT -> IDLE when sack[w-1]=1 or on timeout; there SHALL be no other states.
REQ-013 In WAIT, the cycle sack[w-1] is sampled 1: sreq SHALL drop to 0 on the next edge, with armack=1, armerr=serr[w-1] and armrdata=srdata word w-1 in that same cycle.
REQ-014 sack and serr of any slave other than w-1 SHALL be ignored.
REQ-015 Timeout: a 16-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle with sack[w-1]=0.
REQ-016 When the counter equals TMO (TMO>0): sreq SHALL drop, with armack=1, armerr=1 and armrdata=32'hFFFFFFFF on the next cycle.
REQ-017 If sack[w-1] and the timeout condition occur in the same cycle, the ack SHALL win.
REQ-018 An ack arriving after a timeout SHALL be ignored.
REQ-019 With TMO=0, WAIT SHALL last until acknowledged.
REQ-020 Rising edges of armreq during WAIT, or during the completion cycle, SHALL be ignored and not queued.
REQ-021 armack SHALL be 1 for exactly one cycle per access; at most one access SHALL be outstanding; at most one sreq bit SHALL be 1 at any time.
REQ-022 armrdata and armerr SHALL hold their last values between acks.

Reset
REQ-023 While rstn=0: state SHALL be IDLE, and armreq0, armack, armerr, armrdata, ctl, sreq, swr, saddr, swdata, swstrb and the timeout counter SHALL all be 0.
REQ-024 Reset asserted in WAIT SHALL abandon the access: sreq SHALL go to 0 immediately and no armack SHALL follow.
REQ-025 armreq=1 at reset release SHALL count as a rising edge on the first clock.

Verification
REQ-026 Write 0x11223344 to addr 0x000004 with armwstrb=4'b0101 after reset -> one cycle later armack=1, armerr=0, ctl reg1 = 0x00220044.
REQ-027 Read addr 0x000000+4*NREG with sts=0xCAFEF00D -> armack next cycle, armrdata=0xCAFEF00D; write to the same address -> armerr=1 and ctl unchanged.
REQ-028 Read addr 0x200010 with NSLV=2; slave 1 acks after 3 cycles with srdata word1=0x0BADC0DE and serr[1]=0 -> saddr=0x00010 and sreq=2'b10 held 3 cycles, then armack with armrdata=0x0BADC0DE.
REQ-029 TMO=4, access to window 1, sack held 0 -> sreq[0] high for 5 cycles, then armack=1, armerr=1, armrdata=0xFFFFFFFF; a later sack[0] pulse produces no armack.
REQ-030 Access to window 0xF -> armack=1, armerr=1 next cycle, sreq stays 0; an armreq re-edge during WAIT produces no second armack.
